// File: rtl/debouncer_pkg.sv
// ============================================================================
// Module  : debouncer_pkg
// Brief   : Shared widths and 125 MHz board defaults for the debouncer block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package debouncer_pkg;

    // Board defaults: 0.5 ms sample tick at 125 MHz, 200 ticks = 100 ms hold.
    localparam int c_default_sample_cnt_max = 62500;
    localparam int c_default_pulse_cnt_max  = 200;

    // Tick counter spans 0..SAMPLE_CNT_MAX-1.
    function automatic int tick_width(input int sample_cnt_max);
        return ($clog2(sample_cnt_max) < 1) ? 1 : $clog2(sample_cnt_max);
    endfunction

    // Saturating counter spans 0..PULSE_CNT_MAX inclusive.
    function automatic int sat_width(input int pulse_cnt_max);
        return ($clog2(pulse_cnt_max + 1) < 1) ? 1 : $clog2(pulse_cnt_max + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debouncer_sample_tick_gen.sv
// ============================================================================
// Module  : sample_tick_gen
// Brief   : Free-running modulo-SAMPLE_CNT_MAX counter; tick is high on the
//           last count of each period.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_tick_gen
    import debouncer_pkg::*;
#(
    parameter int SAMPLE_CNT_MAX = c_default_sample_cnt_max
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                  c_tick_w = tick_width(SAMPLE_CNT_MAX);
    localparam logic [c_tick_w-1:0] c_last   = c_tick_w'(SAMPLE_CNT_MAX - 1);
    localparam logic [c_tick_w-1:0] c_one    = c_tick_w'(1);

    logic [c_tick_w-1:0] r_tick_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_last) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_one;
        end
    end

    assign tick = (r_tick_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/debouncer.sv
// ============================================================================
// Module  : debouncer
// Brief   : Per-bit assert-only debouncer with a shared sample tick.
//           Optional rise_pulse output enabled by DEBOUNCER_RISE_PULSE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer
    import debouncer_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = c_default_sample_cnt_max,
    parameter int PULSE_CNT_MAX  = c_default_pulse_cnt_max
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
`ifdef DEBOUNCER_RISE_PULSE_EN
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse
`else
    output logic [WIDTH-1:0] debounced_signal
`endif
);

    localparam int                 c_sat_w   = sat_width(PULSE_CNT_MAX);
    localparam logic [c_sat_w-1:0] c_sat_max = c_sat_w'(PULSE_CNT_MAX);
    localparam logic [c_sat_w-1:0] c_one     = c_sat_w'(1);

    logic w_tick;

    sample_tick_gen #(
        .SAMPLE_CNT_MAX(SAMPLE_CNT_MAX)
    ) u_sample_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(w_tick)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [c_sat_w-1:0] r_sat_cnt;

        // A low sample clears immediately, even on a tick cycle; release is not debounced.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sat_cnt <= '0;
            end else if (!glitchy_signal[i]) begin
                r_sat_cnt <= '0;
            end else if (w_tick && (r_sat_cnt < c_sat_max)) begin
                r_sat_cnt <= r_sat_cnt + c_one;
            end
        end

        assign debounced_signal[i] = (r_sat_cnt == c_sat_max);
    end

`ifdef DEBOUNCER_RISE_PULSE_EN
    logic [WIDTH-1:0] r_deb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_q <= '0;
        end else begin
            r_deb_q <= debounced_signal;
        end
    end

    assign rise_pulse = debounced_signal & ~r_deb_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_debouncer.sv
// ============================================================================
// Module  : tb_debouncer
// Brief   : Directed plus random check of debouncer against an arithmetic
//           model (tick counting between last clear and now).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debouncer;

    localparam int WIDTH = 2;
    localparam int S     = 4;
    localparam int P     = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] glitchy_signal;
    logic [WIDTH-1:0] debounced_signal;
`ifdef DEBOUNCER_RISE_PULSE_EN
    logic [WIDTH-1:0] rise_pulse;
`endif

    int n_cmp;
    int n_err;
    int edge_n;
    int rst_edge;
    int last_low [WIDTH];
    logic [WIDTH-1:0] exp_deb;
    logic [WIDTH-1:0] prev_deb;

    debouncer #(
        .WIDTH         (WIDTH),
        .SAMPLE_CNT_MAX(S),
        .PULSE_CNT_MAX (P)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .glitchy_signal  (glitchy_signal),
`ifdef DEBOUNCER_RISE_PULSE_EN
        .debounced_signal(debounced_signal),
        .rise_pulse      (rise_pulse)
`else
        .debounced_signal(debounced_signal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ticks fall on edges k with (k - rst_edge) a positive multiple of S; a bit
    // is asserted once P of them have elapsed since its last low sample or reset.
    task automatic step(input logic r, input logic [WIDTH-1:0] g, input string tag);
        rst            = r;
        glitchy_signal = g;
        @(posedge clk);
        edge_n++;
        if (r) begin
            rst_edge = edge_n;
            for (int i = 0; i < WIDTH; i++) last_low[i] = edge_n;
        end else begin
            for (int i = 0; i < WIDTH; i++) if (!g[i]) last_low[i] = edge_n;
        end
        prev_deb = exp_deb;
        for (int i = 0; i < WIDTH; i++)
            exp_deb[i] = (((edge_n - rst_edge) / S) - ((last_low[i] - rst_edge) / S)) >= P;
        if (r) prev_deb = '0;
        #1;
        n_cmp++;
        assert (debounced_signal === exp_deb) else begin
            n_err++;
            $error("FAIL %s deb edge=%0d observed=%b expected=%b", tag, edge_n, debounced_signal, exp_deb);
        end
`ifdef DEBOUNCER_RISE_PULSE_EN
        n_cmp++;
        assert (rise_pulse === (exp_deb & ~prev_deb)) else begin
            n_err++;
            $error("FAIL %s rise edge=%0d observed=%b expected=%b", tag, edge_n, rise_pulse,
                   exp_deb & ~prev_deb);
        end
`endif
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        edge_n   = 0;
        rst_edge = 0;
        exp_deb  = '0;
        prev_deb = '0;
        for (int i = 0; i < WIDTH; i++) last_low[i] = 0;
        rst            = 1'b1;
        glitchy_signal = '0;

        // Reset then bit0 held high: assert after 3 ticks, then hold.
        step(1'b1, 2'b00, "reset");
        step(1'b1, 2'b00, "reset");
        for (int c = 0; c < 20; c++) step(1'b0, 2'b01, "assert");

        // One-cycle dropout mid-count restarts the full 3-tick wait.
        step(1'b1, 2'b00, "reset2");
        for (int c = 0; c < 9; c++) step(1'b0, 2'b01, "glitch_pre");
        step(1'b0, 2'b00, "glitch");
        for (int c = 0; c < 16; c++) step(1'b0, 2'b01, "glitch_post");

        // Release of bit0 is immediate and leaves bit1 alone.
        for (int c = 0; c < 14; c++) step(1'b0, 2'b11, "both_up");
        step(1'b0, 2'b10, "release");
        step(1'b0, 2'b10, "release");
        step(1'b0, 2'b11, "reraise");

        // Long hold: counters saturate and stay asserted.
        for (int c = 0; c < 40; c++) step(1'b0, 2'b11, "saturate");

        // Reset pulse mid-count discards progress.
        step(1'b1, 2'b00, "reset3");
        for (int c = 0; c < 5; c++) step(1'b0, 2'b11, "pre_rst");
        step(1'b1, 2'b11, "mid_rst");
        for (int c = 0; c < 14; c++) step(1'b0, 2'b11, "post_rst");

        // Random: mostly-high bouncy inputs, rare resets.
        for (int c = 0; c < 800; c++) begin
            logic [WIDTH-1:0] g;
            for (int i = 0; i < WIDTH; i++) g[i] = ($urandom_range(0, 19) != 0);
            step(($urandom_range(0, 199) == 0), g, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
